// File: rtl/weight_pingpong_sched_if.sv
// weight_pingpong_sched_if: config, weight-stream and bank-control signals of the ping/pong weight scheduler
interface weight_pingpong_sched_if #(
  parameter int WR_ADDR_DEPTH = 10,
  parameter int RD_ADDR_DEPTH = 8,
  parameter int CNT_W = 8
);
  logic cfg_valid, cfg_ready;
  logic [RD_ADDR_DEPTH:0] cfg_rd_len;
  logic [CNT_W-1:0] cfg_tiles, cfg_reuse;
  logic wdata_valid, wdata_ready;
  logic [1:0] bank_we;
  logic [WR_ADDR_DEPTH-1:0] addr_wr;
  logic rd_req, rd_en, rd_bank, rd_last, layer_done;
  logic [RD_ADDR_DEPTH-1:0] addr_rd;
  modport master (
    output cfg_valid, cfg_rd_len, cfg_tiles, cfg_reuse, wdata_valid, rd_req,
    input cfg_ready, wdata_ready, bank_we, addr_wr, rd_en, rd_bank, addr_rd, rd_last, layer_done
  );
  modport slave (
    input cfg_valid, cfg_rd_len, cfg_tiles, cfg_reuse, wdata_valid, rd_req,
    output cfg_ready, wdata_ready, bank_we, addr_wr, rd_en, rd_bank, addr_rd, rd_last, layer_done
  );
endinterface

// File: rtl/weight_pingpong_sched.sv
// weight_pingpong_sched: fills one weight bank from the stream while the PE array replays the other
module weight_pingpong_sched #(
  parameter int WR_ADDR_DEPTH = 10,
  parameter int RD_ADDR_DEPTH = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rstn,
  weight_pingpong_sched_if.slave bus
);
  localparam int RATIO = WR_ADDR_DEPTH - RD_ADDR_DEPTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} top_e;
  typedef enum logic {W_WAIT, W_FILL} wr_e;
  typedef enum logic [1:0] {R_WAIT, R_ARM, R_READ, R_REL} rd_e;
  top_e top_q, top_d;
  wr_e ws_q, ws_d;
  rd_e rs_q, rs_d;
  logic [1:0] full_q, full_d;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RD_ADDR_DEPTH:0] rd_len_q, rd_len_d;
  logic [CNT_W-1:0] tiles_q, tiles_d, reuse_q, reuse_d, twr_q, twr_d, trd_q, trd_d, pass_q, pass_d;
  logic [WR_ADDR_DEPTH-1:0] beat_q, beat_d;
  logic [RD_ADDR_DEPTH-1:0] raddr_q, raddr_d;
  logic [WR_ADDR_DEPTH:0] wr_len;
  logic wready, fire, wr_fin, ren, rlast;
  assign wr_len = (WR_ADDR_DEPTH+1)'(rd_len_q) << RATIO;
  assign wready = ws_q == W_FILL;
  assign fire = bus.wdata_valid & wready;
  assign wr_fin = fire & ({1'b0, beat_q} == wr_len - (WR_ADDR_DEPTH+1)'(1));
  assign ren = rs_q == R_READ;
  assign rlast = ren & ({1'b0, raddr_q} == rd_len_q - (RD_ADDR_DEPTH+1)'(1));
  assign bus.cfg_ready = top_q == IDLE;
  assign bus.wdata_ready = wready;
  assign bus.bank_we = fire ? (wr_ptr_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.addr_wr = beat_q;
  assign bus.rd_en = ren;
  assign bus.rd_bank = rd_ptr_q;
  assign bus.addr_rd = raddr_q;
  assign bus.rd_last = rlast;
  assign bus.layer_done = top_q == DONE;
  always_comb begin
    top_d = top_q; ws_d = ws_q; rs_d = rs_q; full_d = full_q;
    wr_ptr_d = wr_ptr_q; rd_ptr_d = rd_ptr_q;
    rd_len_d = rd_len_q; tiles_d = tiles_q; reuse_d = reuse_q;
    twr_d = twr_q; trd_d = trd_q; pass_d = pass_q; beat_d = beat_q; raddr_d = raddr_q;
    if (top_q == IDLE && bus.cfg_valid) begin
      top_d = RUN; ws_d = W_WAIT; rs_d = R_WAIT; full_d = '0;
      wr_ptr_d = 1'b0; rd_ptr_d = 1'b0;
      rd_len_d = bus.cfg_rd_len; tiles_d = bus.cfg_tiles; reuse_d = bus.cfg_reuse;
      twr_d = '0; trd_d = '0; pass_d = '0; beat_d = '0; raddr_d = '0;
    end
    if (top_q == DONE) top_d = IDLE;
    if (top_q == RUN) begin
      if (ws_q == W_WAIT && !full_q[wr_ptr_q] && twr_q < tiles_q) ws_d = W_FILL;
      if (fire) beat_d = beat_q + WR_ADDR_DEPTH'(1);
      if (wr_fin) begin
        full_d[wr_ptr_q] = 1'b1; wr_ptr_d = !wr_ptr_q; twr_d = twr_q + CNT_W'(1);
        beat_d = '0; ws_d = W_WAIT;
      end
      if (rs_q == R_WAIT && full_q[rd_ptr_q]) rs_d = R_ARM;
      if (rs_q == R_ARM && bus.rd_req) rs_d = R_READ;
      if (ren) raddr_d = raddr_q + RD_ADDR_DEPTH'(1);
      if (rlast) begin
        raddr_d = '0; pass_d = pass_q + CNT_W'(1);
        rs_d = (pass_q + CNT_W'(1) < reuse_q) ? R_ARM : R_REL;
      end
      // bank flags are registered: the writer sees this release one cycle later
      if (rs_q == R_REL) begin
        full_d[rd_ptr_q] = 1'b0; rd_ptr_d = !rd_ptr_q; trd_d = trd_q + CNT_W'(1);
        pass_d = '0; rs_d = R_WAIT;
        if (trd_q + CNT_W'(1) == tiles_q) top_d = DONE;
      end
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      top_q <= IDLE; ws_q <= W_WAIT; rs_q <= R_WAIT; full_q <= '0;
      wr_ptr_q <= 1'b0; rd_ptr_q <= 1'b0;
      rd_len_q <= '0; tiles_q <= '0; reuse_q <= '0;
      twr_q <= '0; trd_q <= '0; pass_q <= '0; beat_q <= '0; raddr_q <= '0;
    end else begin
      top_q <= top_d; ws_q <= ws_d; rs_q <= rs_d; full_q <= full_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d;
      rd_len_q <= rd_len_d; tiles_q <= tiles_d; reuse_q <= reuse_d;
      twr_q <= twr_d; trd_q <= trd_d; pass_q <= pass_d; beat_q <= beat_d; raddr_q <= raddr_d;
    end
endmodule
